// File: rtl/bitpipe_seq_ctrl_if.sv
// Control bundle between bitpipe_seq_ctrl and its surroundings.
// The master modport is the sequencer side; the slave modport is the
// upstream/downstream/datapath side. With BITPIPE_PERF_EN defined, the
// bundle also carries the two performance counters.
interface bitpipe_seq_ctrl_if #(
  parameter int OCC_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             drain;
  logic             flush;
  logic             pipe_en;
  logic             pipe_clr;
  logic [OCC_W-1:0] occupancy;
  logic             idle;
`ifdef BITPIPE_PERF_EN
  logic [15:0]      perf_accepts;
  logic [15:0]      perf_stalls;
`endif

  modport master (
    input  in_valid,
    input  out_ready,
    input  drain,
    input  flush,
    output in_ready,
    output out_valid,
    output pipe_en,
    output pipe_clr,
    output occupancy,
`ifdef BITPIPE_PERF_EN
    output perf_accepts,
    output perf_stalls,
`endif
    output idle
  );

  modport slave (
    output in_valid,
    output out_ready,
    output drain,
    output flush,
    input  in_ready,
    input  out_valid,
    input  pipe_en,
    input  pipe_clr,
    input  occupancy,
`ifdef BITPIPE_PERF_EN
    input  perf_accepts,
    input  perf_stalls,
`endif
    input  idle
  );
endinterface

// File: rtl/bitpipe_seq_ctrl.sv
// bitpipe_seq_ctrl: control sequencer for a STAGES-deep bit-level register
// pipeline. Tracks one valid token per rank, applies input/output valid/ready
// handshakes, and owns the datapath's global enable and synchronous clear.
// No data passes through this block.
//
// Optional feature: define BITPIPE_PERF_EN to add saturating 16-bit counters
// perf_accepts (accepted operands) and perf_stalls (backpressure stall cycles).
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | pipeline empty, waiting for the first operand
// RUN   | tokens in flight, accepting and shifting
// STALL | last rank holds a result the consumer has not taken; all frozen
// DRAIN | input closed, pipeline empties; held while drain stays high
// FLUSH | single cycle: ranks cleared, enable low
module bitpipe_seq_ctrl #(
  parameter int STAGES = 4,
  parameter int OCC_W  = 6
) (
  input logic               clk,
  input logic               rst,
  bitpipe_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STALL = 3'd2,
    S_DRAIN = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [STAGES-1:0]  vld_q;
  logic [STAGES-1:0]  vld_d;
  logic [OCC_W-1:0]   occ_q;
  logic [OCC_W-1:0]   occ_d;

  logic out_valid;
  logic stall_bp;
  logic pipe_en;
  logic in_ready;
  logic accept;
  logic xfer;

  // Handshake and enable terms, all combinational from state and token bits.
  always_comb begin
    out_valid = vld_q[STAGES-1];
    stall_bp  = out_valid && !bus.out_ready;
    pipe_en   = !stall_bp && (state_q != S_FLUSH);
    in_ready  = pipe_en && ((state_q == S_IDLE) || (state_q == S_RUN))
                && !bus.drain && !bus.flush;
    accept    = bus.in_valid && in_ready;
    xfer      = out_valid && bus.out_ready;
  end

  // Token shift and occupancy update. A flush request clears on the edge it
  // is sampled, so a stalled result disappears in the very next cycle.
  always_comb begin
    vld_d = vld_q;
    occ_d = occ_q;
    if (bus.flush || (state_q == S_FLUSH)) begin
      vld_d = '0;
      occ_d = '0;
    end else begin
      if (pipe_en) begin
        vld_d = {vld_q[STAGES-2:0], accept};
      end
      if (accept && !xfer) begin
        occ_d = occ_q + OCC_W'(1);
      end else if (!accept && xfer) begin
        occ_d = occ_q - OCC_W'(1);
      end
    end
  end

  // Next-state logic; flush overrides everything, drain overrides accept.
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = S_FLUSH;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.drain) begin
            state_d = S_DRAIN;
          end else if (accept) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (bus.drain) begin
            state_d = S_DRAIN;
          end else if (stall_bp) begin
            state_d = S_STALL;
          end else if ((occ_d == '0) && !accept) begin
            state_d = S_IDLE;
          end
        end
        S_STALL: begin
          if (bus.drain) begin
            state_d = S_DRAIN;
          end else if (bus.out_ready) begin
            state_d = S_RUN;
          end
        end
        S_DRAIN: begin
          if (!bus.drain && (occ_q == '0)) begin
            state_d = S_IDLE;
          end
        end
        S_FLUSH: begin
          state_d = bus.drain ? S_DRAIN : S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, token and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vld_q   <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      occ_q   <= occ_d;
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.in_ready  = in_ready;
  assign bus.pipe_en   = pipe_en;
  // Reset clears the datapath ranks in the same cycle it is applied.
  assign bus.pipe_clr  = rst || (state_q == S_FLUSH);
  assign bus.occupancy = occ_q;
  assign bus.idle      = (state_q == S_IDLE);

`ifdef BITPIPE_PERF_EN
  logic [15:0] acc_cnt_q;
  logic [15:0] stall_cnt_q;

  // Saturating performance counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept && (acc_cnt_q != 16'hFFFF)) begin
        acc_cnt_q <= acc_cnt_q + 16'd1;
      end
      if (stall_bp && (state_q != S_FLUSH) && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign bus.perf_accepts = acc_cnt_q;
  assign bus.perf_stalls  = stall_cnt_q;
`endif

endmodule

// File: doc/bitpipe_seq_ctrl.md
Name: bitpipe_seq_ctrl

Overview:
Control sequencer for a bit-level pipelined datapath, i.e. a chain of STAGES D flip-flop register ranks. It owns the pipeline's global enable and synchronous clear. It tracks a valid token per stage, applies valid/ready handshakes at the pipeline input and output, and supports drain and flush. Data does not pass through this block; it drives only the control signals of the datapath.

Parameters:
STAGES, 4, pipeline depth in register ranks; legal range 2..32
OCC_W, 6, occupancy counter width; must satisfy 2^OCC_W > STAGES

Ports:
clk  input  1  rising-edge clock, shared with the datapath
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream has an operand
in_ready  output  1  controller accepts an operand this cycle
out_valid  output  1  the last pipeline rank holds a valid result
out_ready  input  1  downstream accepts a result
drain  input  1  level; stop accepting and empty the pipeline
flush  input  1  one-cycle pulse; discard everything in flight
pipe_en  output  1  global clock enable to all datapath ranks
pipe_clr  output  1  synchronous clear to all datapath ranks
occupancy  output  OCC_W  number of valid tokens in flight
idle  output  1  high when the state is IDLE

Behaviour:
- Reset (rst=1 at a clock edge) sets the token register vld[STAGES-1:0] to 0, state to IDLE, occupancy to 0 and pipe_clr to 1 for that cycle. After reset: in_ready=1, out_valid=0, pipe_en=1, idle=1.
- States: IDLE, RUN, STALL, DRAIN, FLUSH. Encoding is free.
- Combinational outputs:
  - out_valid = vld[STAGES-1]
  - pipe_en = !(out_valid && !out_ready) && state!=FLUSH
  - in_ready = pipe_en && state is IDLE or RUN && !drain && !flush
- Token shift, on each edge with pipe_en=1: vld <= {vld[STAGES-2:0], in_valid&&in_ready}. With pipe_en=0, vld holds.
- Latency: an operand accepted in cycle N produces out_valid in cycle N+STAGES, provided there is no stall.
- Occupancy tracks the popcount of vld. It increments on accept, decrements on an output transfer (out_valid&&out_ready), and is unchanged when both occur in the same cycle. It never exceeds STAGES.
- Transitions:
  - IDLE -> RUN on accept.
  - RUN -> STALL when out_valid && !out_ready.
  - STALL -> RUN when out_ready=1.
  - RUN -> IDLE when occupancy reaches 0 with no accept.
  - IDLE/RUN/STALL -> DRAIN when drain=1. DRAIN still shifts and can stall.
  - DRAIN -> IDLE when occupancy=0 and drain=0.
  - DRAIN holds with idle=0 while drain stays high, even at occupancy 0.
  - Any state -> FLUSH on flush=1. flush has priority over drain and over a simultaneous accept; the accept does not occur because in_ready=0.
  - FLUSH lasts exactly one cycle: pipe_clr=1, vld<=0, occupancy<=0, pipe_en=0. It then goes to IDLE, or to DRAIN if drain=1.
- A flush during a stall discards the stalled result; out_valid drops the next cycle.
- Backpressure stalls the entire pipeline with no bubbles collapsed. Internal bubbles are preserved.
- Reset mid-operation has the same effect as flush, plus a return to the IDLE defaults.

Optional Feature:
- Macro BITPIPE_PERF_EN adds two outputs:
  - perf_accepts[15:0] counts accepted operands.
  - perf_stalls[15:0] counts cycles with pipe_en=0 due to backpressure; FLUSH cycles are not counted.
- Both counters saturate at 16'hFFFF and clear on rst only.
- Without the macro these ports and their counters do not exist, and the remaining behaviour is identical.

Test Plan:
1. STAGES=4, out_ready=1. Drive in_valid=1 for one cycle at cycle 2 -> out_valid=1 only at cycle 6; occupancy goes 1,1,1,1,0; idle returns at cycle 7.
2. Streaming with in_valid=1 for 10 cycles and out_ready=1 -> 10 out_valid pulses in 10 consecutive cycles starting 4 cycles after the first accept; occupancy holds at 4 in steady state.
3. Stall: 4 tokens in flight, drop out_ready for 3 cycles -> pipe_en=0 and in_ready=0 for 3 cycles; vld and occupancy frozen at 4; after release, outputs resume with no token lost or duplicated.
4. Drain: assert drain with 3 in flight -> in_ready=0 immediately; 3 outputs appear; state stays DRAIN until drain=0, then idle=1.
5. Flush: pulse flush while STALL with 4 in flight -> next cycle pipe_clr=1, pipe_en=0; following cycle occupancy=0, out_valid=0, state IDLE; a simultaneous in_valid is not accepted.
6. rst asserted mid-stream -> all outputs return to reset values on the next edge; with BITPIPE_PERF_EN, perf_accepts and perf_stalls read 0.
